// File: rtl/recebe_sequencia_movimentos.sv
// Receives a length-framed move sequence over the UART link and writes each
// validated move code into the move RAM at consecutive addresses.
module recebe_sequencia_movimentos #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 6,
    parameter int                MAX_MOVES   = 54,
    parameter int                VALID_CODES = 18,
    parameter logic [DATA_W-1:0] REQ_BYTE    = 8'h52,
    parameter int                TIMEOUT     = 1_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              tx_pronto,
    input  logic              rx_valido,
    input  logic [DATA_W-1:0] rx_dado,
    output logic              tx_partida,
    output logic [DATA_W-1:0] tx_dado,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_dado,
    output logic [ADDR_W:0]   num_movimentos,
    output logic              ocupado,
    output logic              pronto,
    output logic              erro,
    output logic [1:0]        erro_codigo,
    output logic [3:0]        db_estado
);

    localparam int                TMR_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [31:0]       MAX_U     = MAX_MOVES;
    localparam logic [31:0]       CODES_U   = VALID_CODES;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_LEN     = 2'b10;
    localparam logic [1:0] ERR_CODE    = 2'b11;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        PREP  = 4'd1,
        TX    = 4'd2,
        LEN   = 4'd3,
        RECV  = 4'd4,
        STORE = 4'd5,
        NEXT  = 4'd6,
        DONE  = 4'd7,
        ERRO  = 4'd8
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [ADDR_W:0]   idx_q, idx_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [DATA_W-1:0] dado_q, dado_d;
    logic [1:0]        err_q, err_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [ADDR_W:0]   idx_inc;
    logic              expirou;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= IDLE;
            idx_q    <= '0;
            len_q    <= '0;
            dado_q   <= '0;
            err_q    <= ERR_NONE;
            timer_q  <= '0;
        end else begin
            estado_q <= estado_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            dado_q   <= dado_d;
            err_q    <= err_d;
            timer_q  <= timer_d;
        end
    end

    // The timer idles at zero, so any entry into a waiting state starts a fresh count.
    always_comb begin
        estado_d = estado_q;
        idx_d    = idx_q;
        len_d    = len_q;
        dado_d   = dado_q;
        err_d    = err_q;
        timer_d  = '0;
        idx_inc  = idx_q + 1'b1;
        expirou  = (timer_q == TMR_LAST);

        case (estado_q)
            IDLE, DONE, ERRO: begin
                if (iniciar) begin
                    err_d    = ERR_NONE;
                    estado_d = PREP;
                end
            end
            PREP: begin
                idx_d    = '0;
                len_d    = '0;
                err_d    = ERR_NONE;
                estado_d = TX;
            end
            TX: begin
                if (tx_pronto) begin
                    estado_d = LEN;
                end else if (expirou) begin
                    err_d    = ERR_TIMEOUT;
                    estado_d = ERRO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            LEN: begin
                if (rx_valido) begin
                    if (rx_dado == '0) begin
                        len_d    = '0;
                        estado_d = DONE;
                    end else if (32'(rx_dado) > MAX_U) begin
                        err_d    = ERR_LEN;
                        estado_d = ERRO;
                    end else begin
                        len_d    = (ADDR_W+1)'(rx_dado);
                        estado_d = RECV;
                    end
                end else if (expirou) begin
                    err_d    = ERR_TIMEOUT;
                    estado_d = ERRO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            RECV: begin
                if (rx_valido) begin
                    if (32'(rx_dado) >= CODES_U) begin
                        err_d    = ERR_CODE;
                        estado_d = ERRO;
                    end else begin
                        dado_d   = rx_dado;
                        estado_d = STORE;
                    end
                end else if (expirou) begin
                    err_d    = ERR_TIMEOUT;
                    estado_d = ERRO;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STORE: estado_d = NEXT;
            NEXT: begin
                idx_d    = idx_inc;
                estado_d = (idx_inc == len_q) ? DONE : RECV;
            end
            default: estado_d = IDLE;
        endcase
    end

    assign tx_partida     = (estado_q == PREP);
    assign tx_dado        = REQ_BYTE;
    assign mem_we         = (estado_q == STORE);
    assign mem_addr       = idx_q[ADDR_W-1:0];
    assign mem_dado       = dado_q;
    assign num_movimentos = len_q;
    assign ocupado        = (estado_q != IDLE) && (estado_q != DONE) && (estado_q != ERRO);
    assign pronto         = (estado_q == DONE);
    assign erro           = (estado_q == ERRO);
    assign erro_codigo    = err_q;
    assign db_estado      = estado_q;

endmodule
